truth_table_sequencer: RTL



---
 rtl/tts_pkg.sv | 16 +
 rtl/tts_hold_timer.sv | 45 ++++
 rtl/truth_table_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sequencer.
// FSM state encodings and the table-width helper.
package tts_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tts_state_e;

   // Number of entries in a truth table with n inputs.
   function automatic int tt_width(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/tts_hold_timer.sv
// Hold counter for the truth-table sequencer.
// Pulses tc on the last clock of each vector hold.
module tts_hold_timer
   import tts_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Wrap at LAST so every hold window is exactly HOLD_CYCLES long.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   // Terminal count is only meaningful while counting.
   always_comb begin
      tc = en && !clr && (cnt_q == LAST);
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all input combinations, captures f into a truth table.
// Define TTS_GRAY_ORDER_EN to walk stim in reflected Gray order.
module truth_table_sequencer
   import tts_pkg::*;
#(
   parameter int N_INPUTS    = 3,
   parameter int HOLD_CYCLES = 4,
   parameter logic [(1 << N_INPUTS)-1:0] EXPECTED = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            f_in,
   output logic [N_INPUTS-1:0]             stim,
   output logic                            busy,
   output logic                            done,
   output logic [tt_width(N_INPUTS)-1:0]   tt,
   output logic                            match,
   output logic [N_INPUTS:0]               mismatch_count
);

   localparam int TW = tt_width(N_INPUTS);
   localparam logic [N_INPUTS-1:0] KLAST = '1;

   tts_state_e          state_q, state_d;
   logic [N_INPUTS-1:0] k_q, k_d;
   logic [N_INPUTS-1:0] stim_q, stim_d;
   logic [TW-1:0]       tt_q, tt_d;
   logic [N_INPUTS:0]   mc_q, mc_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                match_q, match_d;
   logic                start_ok;
   logic                tc;

   assign start_ok = start && (state_q != RUN);

   tts_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (start_ok),
      .en  (state_q == RUN),
      .tc  (tc)
   );

   // Step counter k maps to the stimulus order.
`ifdef TTS_GRAY_ORDER_EN
   assign stim_d = k_d ^ (k_d >> 1);
`else
   assign stim_d = k_d;
`endif

   // Next state, capture and bookkeeping.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      tt_d    = tt_q;
      mc_d    = mc_q;
      busy_d  = busy_q;
      done_d  = done_q;
      match_d = match_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               k_d     = '0;
               tt_d    = '0;
               mc_d    = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               match_d = 1'b0;
            end
         end
         RUN: begin
            if (tc) begin
               tt_d[stim_q] = f_in;
               if (f_in != EXPECTED[stim_q]) begin
                  mc_d = mc_q + (N_INPUTS+1)'(1);
               end
               if (k_q == KLAST) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  match_d = (tt_d == EXPECTED);
               end else begin
                  k_d = k_q + N_INPUTS'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         stim_q  <= '0;
         tt_q    <= '0;
         mc_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         stim_q  <= stim_d;
         tt_q    <= tt_d;
         mc_q    <= mc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         match_q <= match_d;
      end
   end

   assign stim           = stim_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign tt             = tt_q;
   assign match          = match_q;
   assign mismatch_count = mc_q;

endmodule
